nic_ring_inject: RTL and testbench

Per-node ring access controller for the NIC packet ring. It sits in the packet ring between the upstream node and the ager. It removes packets addressed to this node into a one-entry receive register. It grants free ring slots to NREQ local requesters in round-robin order, so that only one packet enters the ring per cycle.

---
 rtl/nic_pkg.sv | 26 ++
 rtl/nic_ring_inject_if.sv | 14 +
 rtl/nic_rr_arb.sv | 42 ++++
 rtl/nic_ring_inject.sv | 118 +++++++++++
 tb/tb_nic_ring_inject.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared NIC ring packet types and helpers
package nic_pkg;

    typedef enum logic [1:0] {
        PT_DATA = 2'd0,
        PT_CTRL = 2'd1,
        PT_RESP = 2'd2,
        PT_MGMT = 2'd3
    } pkt_type_t;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [3:0]  age;
        pkt_type_t   ptype;
        logic [15:0] data;
    } packet_t;

    localparam logic [5:0] NIC_BCAST_ID = 6'd63;

    // A slot with neither source nor destination carries no packet.
    function automatic logic NIC_EMPTY(input packet_t p);
        return (p.did | p.sid) == 6'd0;
    endfunction

endpackage

// File: rtl/nic_ring_inject_if.sv
// rtl/nic_ring_inject_if.sv - local transmit requester bus
interface nic_ring_inject_if
    import nic_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    tx_req;
    packet_t [NREQ-1:0] tx_packet;
    logic [NREQ-1:0]    tx_ack;
    logic [NREQ-1:0]    tx_err;

    modport master (output tx_req, output tx_packet, input tx_ack, input tx_err);
    modport slave  (input tx_req, input tx_packet, output tx_ack, output tx_err);
endinterface

// File: rtl/nic_rr_arb.sv
// rtl/nic_rr_arb.sv - round-robin arbiter granting one requester per free slot
module nic_rr_arb #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // Search from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && en && req[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; held when nobody is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: rtl/nic_ring_inject.sv
// rtl/nic_ring_inject.sv - per-node ring receive and round-robin injection
module nic_ring_inject
    import nic_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int STARVE_LIM = 15,
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [5:0]        id_i,
    input  packet_t           packet_i,
    output packet_t           packet_o,
    nic_ring_inject_if.slave  tx,
    output logic              rx_valid_o,
    output packet_t           rx_packet_o,
    input  logic              rx_ready_i,
    output logic              starve_o
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic            slot_empty, is_bcast, for_me, own_bcast;
    logic            rx_space, capture, slot_free;
    logic [NREQ-1:0] elig, gnt, ack_q, err_q;
    logic [PW-1:0]   rr_ptr;
    logic            gvalid, bad;
    packet_t         gpkt, inj, next_pkt, packet_q, rx_q;
    logic            rx_valid_q;
    logic [3:0]      wait_cnt [NREQ];

    assign slot_empty = NIC_EMPTY(packet_i);
    assign is_bcast   = packet_i.did == NIC_BCAST_ID;
    assign for_me     = !slot_empty && (packet_i.did == id_i);
    assign own_bcast  = is_bcast && (packet_i.sid == id_i);
    assign rx_space   = !rx_valid_q || rx_ready_i;
    assign capture    = rx_space && (for_me || (is_bcast && !own_bcast));
    assign slot_free  = slot_empty || (for_me && rx_space) || own_bcast;

    // A requester still showing its ack cannot win again while it drops req.
    assign elig = tx.tx_req & ~ack_q;

    nic_rr_arb #(.N(NREQ)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (elig),
        .en     (slot_free),
        .gnt    (gnt),
        .ptr    (rr_ptr)
    );

    // Select the winner's packet, stamp it with our ID, and build the next slot.
    always_comb begin
        gpkt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gpkt = tx.tx_packet[i];
        end
        gvalid  = |gnt;
        bad     = (gpkt.did == 6'd0) || (gpkt.did == id_i);
        inj     = gpkt;
        inj.sid = id_i;
        inj.age = '0;
        if (!slot_free)          next_pkt = packet_i;
        else if (gvalid && !bad) next_pkt = inj;
        else                     next_pkt = '0;
    end

    // Ring slot register with ack/err pulses aligned to the injected slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            packet_q <= '0;
            ack_q    <= '0;
            err_q    <= '0;
        end else begin
            packet_q <= next_pkt;
            ack_q    <= bad ? '0 : gnt;
            err_q    <= bad ? gnt : '0;
        end
    end

    // One-entry receive register; capture and drain in one cycle keeps it full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid_q <= 1'b0;
            rx_q       <= '0;
        end else if (capture) begin
            rx_valid_q <= 1'b1;
            rx_q       <= packet_i;
        end else if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Per-requester wait counters, cleared at the grant edge so starve drops with the ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!tx.tx_req[i] || gnt[i] || ack_q[i]) wait_cnt[i] <= '0;
                else if (wait_cnt[i] != LIM)             wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end

    // Starvation flag is any requester sitting at the limit.
    always_comb begin
        starve_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (wait_cnt[i] == LIM) starve_o = 1'b1;
        end
    end

    assign packet_o    = packet_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_packet_o = rx_q;
    assign tx.tx_ack   = ack_q;
    assign tx.tx_err   = err_q;
endmodule

// File: tb/tb_nic_ring_inject.sv
// tb/tb_nic_ring_inject.sv - directed self-checking bench for nic_ring_inject
module tb_nic_ring_inject;
    import nic_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [5:0] id_i;
    packet_t    packet_i, packet_o, rx_packet_o;
    logic       rx_valid_o, rx_ready_i, starve_o;

    int checks = 0;
    int errors = 0;

    packet_t z, p0, p1, inj0, inj1, pa, pb, pc, bc9, bc5, fgn;

    always #5 clk_i = ~clk_i;

    nic_ring_inject_if #(.NREQ(2)) tx_bus ();

    nic_ring_inject #(.NREQ(2), .STARVE_LIM(15)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .id_i        (id_i),
        .packet_i    (packet_i),
        .packet_o    (packet_o),
        .tx          (tx_bus.slave),
        .rx_valid_o  (rx_valid_o),
        .rx_packet_o (rx_packet_o),
        .rx_ready_i  (rx_ready_i),
        .starve_o    (starve_o)
    );

    function automatic packet_t mk(input logic [5:0] d, input logic [5:0] s,
                                   input logic [3:0] a, input pkt_type_t t,
                                   input logic [15:0] dat);
        packet_t p;
        p.did = d; p.sid = s; p.age = a; p.ptype = t; p.data = dat;
        return p;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tx_bus.tx_req = 2'b11;
        packet_i = pa;
        rx_ready_i = 1'b0;
        repeat (2) step();
        checks++; if (packet_o !== z) begin errors++; $display("FAIL reset_pkt: got %h expected %h", packet_o, z); end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rxv: got %b expected 0", rx_valid_o); end
        checks++; if (rx_packet_o !== z) begin errors++; $display("FAIL reset_rxp: got %h expected %h", rx_packet_o, z); end
        checks++; if (tx_bus.tx_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", tx_bus.tx_ack); end
        checks++; if (tx_bus.tx_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", tx_bus.tx_err); end
        checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b expected 0", starve_o); end
        tx_bus.tx_req = 2'b00;
        packet_i = z;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack [3];
        packet_t    exp_pkt [3];
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01;
        exp_pkt[0] = inj0;  exp_pkt[1] = inj1;  exp_pkt[2] = inj0;
        packet_i = z;
        tx_bus.tx_req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (tx_bus.tx_ack !== exp_ack[k]) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", k, tx_bus.tx_ack, exp_ack[k]); end
            checks++; if (packet_o !== exp_pkt[k]) begin errors++; $display("FAIL rr_pkt%0d: got %h expected %h", k, packet_o, exp_pkt[k]); end
        end
        tx_bus.tx_req = 2'b00;
        step();
        checks++; if (tx_bus.tx_ack !== 2'b00) begin errors++; $display("FAIL rr_idle_ack: got %b expected 00", tx_bus.tx_ack); end
        checks++; if (packet_o !== z) begin errors++; $display("FAIL rr_idle_pkt: got %h expected %h", packet_o, z); end
    endtask

    task automatic test_rx_path();
        packet_i = pa; rx_ready_i = 1'b0;
        step();
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL rx_cap_valid: got %b expected 1", rx_valid_o); end
        checks++; if (rx_packet_o !== pa) begin errors++; $display("FAIL rx_cap_pkt: got %h expected %h", rx_packet_o, pa); end
        checks++; if (packet_o !== z) begin errors++; $display("FAIL rx_cap_slot: got %h expected %h", packet_o, z); end
        packet_i = pb;
        step();
        checks++; if (packet_o !== pb) begin errors++; $display("FAIL rx_full_pass: got %h expected %h", packet_o, pb); end
        checks++; if (rx_packet_o !== pa) begin errors++; $display("FAIL rx_full_hold: got %h expected %h", rx_packet_o, pa); end
        packet_i = pc; rx_ready_i = 1'b1; tx_bus.tx_req = 2'b01;
        step();
        checks++; if (rx_packet_o !== pc) begin errors++; $display("FAIL rx_swap_pkt: got %h expected %h", rx_packet_o, pc); end
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL rx_swap_valid: got %b expected 1", rx_valid_o); end
        checks++; if (packet_o !== inj0) begin errors++; $display("FAIL rx_swap_inject: got %h expected %h", packet_o, inj0); end
        checks++; if (tx_bus.tx_ack !== 2'b01) begin errors++; $display("FAIL rx_swap_ack: got %b expected 01", tx_bus.tx_ack); end
        tx_bus.tx_req = 2'b00; packet_i = z;
        step();
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rx_drain: got %b expected 0", rx_valid_o); end
        rx_ready_i = 1'b0;
    endtask

    task automatic test_bcast();
        packet_i = bc9;
        step();
        checks++; if (packet_o !== bc9) begin errors++; $display("FAIL bc_forward: got %h expected %h", packet_o, bc9); end
        checks++; if (rx_packet_o !== bc9 || rx_valid_o !== 1'b1) begin errors++; $display("FAIL bc_copy: got %b/%h expected 1/%h", rx_valid_o, rx_packet_o, bc9); end
        packet_i = bc5; rx_ready_i = 1'b1; tx_bus.tx_req = 2'b10;
        step();
        checks++; if (packet_o !== inj1) begin errors++; $display("FAIL bc_own_inject: got %h expected %h", packet_o, inj1); end
        checks++; if (tx_bus.tx_ack !== 2'b10) begin errors++; $display("FAIL bc_own_ack: got %b expected 10", tx_bus.tx_ack); end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL bc_own_nocopy: got %b expected 0", rx_valid_o); end
        tx_bus.tx_req = 2'b00;
        step();
        checks++; if (packet_o !== z) begin errors++; $display("FAIL bc_own_remove: got %h expected %h", packet_o, z); end
        packet_i = z; rx_ready_i = 1'b0;
    endtask

    task automatic test_err();
        tx_bus.tx_packet[0] = mk(6'd5, 6'd0, 4'd1, PT_DATA, 16'h5555);
        tx_bus.tx_req = 2'b01;
        step();
        checks++; if (tx_bus.tx_err !== 2'b01 || tx_bus.tx_ack !== 2'b00) begin errors++; $display("FAIL err_own: got err %b ack %b expected err 01 ack 00", tx_bus.tx_err, tx_bus.tx_ack); end
        checks++; if (packet_o !== z) begin errors++; $display("FAIL err_own_pkt: got %h expected %h", packet_o, z); end
        tx_bus.tx_req = 2'b00;
        tx_bus.tx_packet[1] = mk(6'd0, 6'd3, 4'd2, PT_MGMT, 16'h0F0F);
        step();
        checks++; if (tx_bus.tx_err !== 2'b00) begin errors++; $display("FAIL err_single: got %b expected 00", tx_bus.tx_err); end
        tx_bus.tx_req = 2'b10;
        step();
        checks++; if (tx_bus.tx_err !== 2'b10 || tx_bus.tx_ack !== 2'b00) begin errors++; $display("FAIL err_zero: got err %b ack %b expected err 10 ack 00", tx_bus.tx_err, tx_bus.tx_ack); end
        checks++; if (packet_o !== z) begin errors++; $display("FAIL err_zero_pkt: got %h expected %h", packet_o, z); end
        tx_bus.tx_req = 2'b00;
        tx_bus.tx_packet[0] = p0;
        tx_bus.tx_packet[1] = p1;
        step();
    endtask

    task automatic test_starve();
        packet_i = fgn;
        tx_bus.tx_req = 2'b01;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++; if (starve_o !== (k >= 15)) begin errors++; $display("FAIL starve_w%0d: got %b expected %b", k, starve_o, (k >= 15)); end
            checks++; if (packet_o !== fgn) begin errors++; $display("FAIL starve_pass%0d: got %h expected %h", k, packet_o, fgn); end
        end
        packet_i = z;
        step();
        checks++; if (tx_bus.tx_ack !== 2'b01) begin errors++; $display("FAIL starve_ack: got %b expected 01", tx_bus.tx_ack); end
        checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL starve_clear: got %b expected 0", starve_o); end
        checks++; if (packet_o !== inj0) begin errors++; $display("FAIL starve_inject: got %h expected %h", packet_o, inj0); end
        tx_bus.tx_req = 2'b00;
        step();
    endtask

    task automatic test_async_reset();
        packet_i = pa; rx_ready_i = 1'b0; tx_bus.tx_req = 2'b01;
        step();
        checks++; if (packet_o !== inj0 || rx_valid_o !== 1'b1) begin errors++; $display("FAIL ar_setup: got %h/%b expected %h/1", packet_o, rx_valid_o, inj0); end
        #3;
        rst_ni = 1'b0;
        #1;
        checks++; if (packet_o !== z) begin errors++; $display("FAIL ar_pkt: got %h expected %h", packet_o, z); end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL ar_rxv: got %b expected 0", rx_valid_o); end
        checks++; if (rx_packet_o !== z) begin errors++; $display("FAIL ar_rxp: got %h expected %h", rx_packet_o, z); end
        checks++; if (tx_bus.tx_ack !== 2'b00) begin errors++; $display("FAIL ar_ack: got %b expected 00", tx_bus.tx_ack); end
        step();
        checks++; if (packet_o !== z || tx_bus.tx_ack !== 2'b00) begin errors++; $display("FAIL ar_hold: got %h/%b expected %h/00", packet_o, tx_bus.tx_ack, z); end
        tx_bus.tx_req = 2'b00;
        rst_ni = 1'b1;
    endtask

    initial begin
        z    = '0;
        p0   = mk(6'd7,  6'd0,  4'd3, PT_CTRL, 16'h1111);
        p1   = mk(6'd9,  6'd2,  4'd6, PT_RESP, 16'h2222);
        inj0 = mk(6'd7,  6'd5,  4'd0, PT_CTRL, 16'h1111);
        inj1 = mk(6'd9,  6'd5,  4'd0, PT_RESP, 16'h2222);
        pa   = mk(6'd5,  6'd9,  4'd2, PT_DATA, 16'hAAAA);
        pb   = mk(6'd5,  6'd12, 4'd4, PT_DATA, 16'hBBBB);
        pc   = mk(6'd5,  6'd14, 4'd1, PT_CTRL, 16'hCCCC);
        bc9  = mk(6'd63, 6'd9,  4'd1, PT_RESP, 16'h0B0B);
        bc5  = mk(6'd63, 6'd5,  4'd2, PT_MGMT, 16'h0505);
        fgn  = mk(6'd20, 6'd30, 4'd5, PT_DATA, 16'h1234);
        id_i = 6'd5;
        tx_bus.tx_packet[0] = p0;
        tx_bus.tx_packet[1] = p1;
        test_reset();
        test_round_robin();
        test_rx_path();
        test_bcast();
        test_err();
        test_starve();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
